cfu_mac_sequencer: RTL and testbench
====================================

# cfu_mac_sequencer

Sequences the CFU's 4-lane int8 SIMD multiply-accumulate datapath over a vector of N 32-bit words held in main RAM. It sits between the CPU's CFU command/response port and the CFU's Wishbone master port to RAM. One RUN command alternately fetches input and filter words over Wishbone, feeds each pair to the MAC datapath and returns the 32-bit dot product. The CPU no longer issues one CFU op per word.

## Interface
Parameters:
- INPUT_OFFSET, default 128: signed offset added to each input byte before multiply.
- CNT_W, default 16: width of the word-count register.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, asynchronous and active-high.
- cmd_valid / cmd_ready  in / out  1  CFU command handshake.
- cmd_payload_function_id  in  10  bits [2:0] select the op; bits [9:3] are ignored.
- cmd_payload_inputs_0, cmd_payload_inputs_1  in  32  operands.
- rsp_valid / rsp_ready  out / in  1  CFU response handshake.
- rsp_payload_outputs_0  out  32  result.
- cfu_ram_adr  out  30  word address.
- cfu_ram_dat_mosi  out  32  always 0.
- cfu_ram_sel  out  4  always 4'b1111.
- cfu_ram_cyc, cfu_ram_stb  out  1  bus request.
- cfu_ram_we  out  1  always 0.
- cfu_ram_cti  out  3  always 0.
- cfu_ram_bte  out  2  always 0.
- cfu_ram_dat_miso  in  32  read data.
- cfu_ram_ack, cfu_ram_err  in  1  bus completion.

## Operation
- Ops, selected by function_id[2:0]:
  - 0 CONFIG: filt_base ← inputs_0[31:2]; count ← inputs_1[CNT_W-1:0]; response 0.
  - 1 RUN: in_base ← inputs_0[31:2]; acc ← 0; idx ← 0; runs the fetch loop; response is the final acc.
  - 2 STATUS: response {31'b0, err}; err is cleared on the same accept.
  - 3–7: response 0, no side effects.
- States: IDLE, RD_IN, RD_FLT, MAC, RESP.
  - IDLE: cmd_ready=1. On accept, RUN with count≠0 → RD_IN; every other op (and RUN with count=0) → RESP.
  - RD_IN: cyc=stb=1, adr=in_base+idx. On ack, latch input word → RD_FLT.
  - RD_FLT: cyc=stb=1, adr=filt_base+idx. On ack, latch filter word → MAC.
  - MAC: cyc=stb=0. acc ← acc + Σ lanes of (sext(in[8k+7:8k]) + INPUT_OFFSET) × sext(flt[8k+7:8k]), k=0..3; idx++. Go to RESP if idx+1==count, else RD_IN.
  - RESP: rsp_valid=1; stays until rsp_ready, then → IDLE.
- Bus error: err sampled in RD_IN or RD_FLT drops cyc/stb, sets sticky err and goes to RESP with result 32'h8000_0000. If ack and err arrive in the same cycle, err wins.
- Arithmetic: each lane is a 9-bit offset operand × 8-bit filter, held as a 17-bit signed product. The lane sum is a 19-bit signed value, sign-extended to 32 bits. Without saturation, acc wraps modulo 2^32.
- Address arithmetic wraps modulo 2^30.
- cmd_ready=0 in every state except IDLE; commands are never queued.
- Reset values: rsp_valid=0, rsp_payload_outputs_0=0, cyc=stb=0, adr=0, state=IDLE. acc, idx, bases, count and err are all 0.
- Reset mid-transfer drops cyc/stb immediately (asynchronous). Any pending response is lost.

## Timing
- With a zero-wait slave (ack in the first cycle stb is high), each word pair takes 3 cycles: RD_IN, RD_FLT, MAC.
- RUN with count=N≥1: rsp_valid rises 3N cycles after the accepting edge. Slave wait states add one cycle per wait.
- CONFIG, STATUS, undefined ops and RUN with count=0: rsp_valid rises 1 cycle after accept.
- cyc/stb stay asserted until ack or err. adr is stable throughout a transaction.
- cyc deasserts for exactly the MAC cycle between pairs.
- rsp_payload_outputs_0 is stable while rsp_valid=1. The earliest next accept is the cycle after the rsp_valid&&rsp_ready edge.

## Configuration
- CFU_MAC_SAT_EN defined: acc addition saturates to [32'h8000_0000, 32'h7FFF_FFFF].
- Not defined: acc wraps modulo 2^32.
- The error code 32'h8000_0000 is identical in both builds; err status disambiguates it.

## Structure
- Package cfu_mac_pkg holds the state enum, the function-id localparams (FN_CONFIG=0, FN_RUN=1, FN_STATUS=2) and ERR_RESULT=32'h8000_0000.
- Sub-module simd_mac4: purely combinational 4-lane offset-multiply-sum, parameterised by INPUT_OFFSET, outputs the 32-bit signed sum. The sequencer owns all registers.

## Test plan
- CONFIG(filt=0x1000, count=1); RUN(in=0x2000); RAM[0x2000]=0x00000000, RAM[0x1000]=0x01010101, zero-wait slave → response 512, rsp_valid 3 cycles after accept.
- count=4; all input bytes 0x7F, all filter bytes 0x80 → each lane 255×(−128); response −522240 (0xFFF80800).
- Slave inserts 2 wait states on every ack, count=2 → response latency 6+8=14 cycles; adr stable while stb is high.
- cfu_ram_err on the second RD_FLT → response 0x80000000, then STATUS returns 1, then STATUS returns 0.
- RUN with count=0 → response 0 after 1 cycle with no cyc assertion. Hold rsp_ready=0 for 5 cycles → rsp_valid and payload held, cmd_ready=0.
- Assert reset during RD_FLT → cyc/stb/rsp_valid are 0 in the same cycle. A subsequent RUN without CONFIG responds 0, because count was reset to 0.

Source files
------------

// File: rtl/cfu_mac_pkg.sv
// Shared types and constants for the CFU MAC sequencer: FSM states, op codes and the bus-error result word.
package cfu_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_IN,
        ST_RD_FLT,
        ST_MAC,
        ST_RESP
    } state_t;

    localparam logic [2:0]  FN_CONFIG  = 3'd0;
    localparam logic [2:0]  FN_RUN     = 3'd1;
    localparam logic [2:0]  FN_STATUS  = 3'd2;

    localparam logic [31:0] ERR_RESULT = 32'h8000_0000;

endpackage

// File: rtl/cfu_mac_sequencer_simd_mac4.sv
// Combinational 4-lane int8 offset-multiply-sum: each lane is (sext(in)+INPUT_OFFSET) * sext(flt), lanes summed and sign-extended to 32 bits.
module simd_mac4 #(
    parameter int INPUT_OFFSET = 128
) (
    input  logic [31:0] in_word,
    input  logic [31:0] flt_word,
    output logic [31:0] sum
);

    localparam logic [8:0] OFFSET = 9'(INPUT_OFFSET);

    logic        [8:0]  op_in  [4];
    logic        [7:0]  op_flt [4];
    logic signed [16:0] prod   [4];
    logic signed [18:0] lane_sum;

    // 9-bit offset operand times 8-bit filter fits a 17-bit signed product; four of them fit 19 bits.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < 4; k++) begin
            op_in[k]  = {in_word[8*k+7], in_word[8*k +: 8]} + OFFSET;
            op_flt[k] = flt_word[8*k +: 8];
            prod[k]   = $signed({{8{op_in[k][8]}}, op_in[k]}) * $signed({{9{op_flt[k][7]}}, op_flt[k]});
            lane_sum  = lane_sum + {{2{prod[k][16]}}, prod[k]};
        end
    end

    assign sum = {{13{lane_sum[18]}}, lane_sum};

endmodule

// File: rtl/cfu_mac_sequencer.sv
// CFU command sequencer that streams input/filter word pairs from RAM over Wishbone through simd_mac4 and returns the dot product.
// Define CFU_MAC_SAT_EN to saturate the accumulator instead of wrapping modulo 2^32.
module cfu_mac_sequencer #(
    parameter int INPUT_OFFSET = 128,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [29:0] cfu_ram_adr,
    output logic [31:0] cfu_ram_dat_mosi,
    output logic [3:0]  cfu_ram_sel,
    output logic        cfu_ram_cyc,
    output logic        cfu_ram_stb,
    output logic        cfu_ram_we,
    output logic [2:0]  cfu_ram_cti,
    output logic [1:0]  cfu_ram_bte,
    input  logic [31:0] cfu_ram_dat_miso,
    input  logic        cfu_ram_ack,
    input  logic        cfu_ram_err
);

    import cfu_mac_pkg::*;

    state_t            state, state_next;
    logic [29:0]       in_base, filt_base;
    logic [CNT_W-1:0]  count, idx;
    logic [31:0]       acc, acc_next, mac_sum, in_word, flt_word, rsp_data;
    logic              err_flag;
    logic [2:0]        op;
    logic              last_pair;
    logic              unused_bits;

    assign op          = cmd_payload_function_id[2:0];
    assign last_pair   = (idx + CNT_W'(1)) == count;
    assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_0[1:0],
                           cmd_payload_inputs_1[31:CNT_W]};

    assign cfu_ram_dat_mosi      = 32'h0;
    assign cfu_ram_sel           = 4'b1111;
    assign cfu_ram_we            = 1'b0;
    assign cfu_ram_cti           = 3'b000;
    assign cfu_ram_bte           = 2'b00;
    assign rsp_payload_outputs_0 = rsp_data;

    simd_mac4 #(.INPUT_OFFSET(INPUT_OFFSET)) u_mac (
        .in_word  (in_word),
        .flt_word (flt_word),
        .sum      (mac_sum)
    );

`ifdef CFU_MAC_SAT_EN
    logic [32:0] acc_wide;
    assign acc_wide = {acc[31], acc} + {mac_sum[31], mac_sum};
    assign acc_next = (acc_wide[32] != acc_wide[31]) ? (acc_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                                     : acc_wide[31:0];
`else
    assign acc_next = acc + mac_sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Bus and handshake outputs decode straight from the state so reset drops them without waiting for an edge.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        cfu_ram_cyc = 1'b0;
        cfu_ram_stb = 1'b0;
        cfu_ram_adr = '0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = (op == FN_RUN && count != '0) ? ST_RD_IN : ST_RESP;
            end
            ST_RD_IN: begin
                cfu_ram_cyc = 1'b1;
                cfu_ram_stb = 1'b1;
                cfu_ram_adr = in_base + 30'(idx);
                if (cfu_ram_err)      state_next = ST_RESP;
                else if (cfu_ram_ack) state_next = ST_RD_FLT;
            end
            ST_RD_FLT: begin
                cfu_ram_cyc = 1'b1;
                cfu_ram_stb = 1'b1;
                cfu_ram_adr = filt_base + 30'(idx);
                if (cfu_ram_err)      state_next = ST_RESP;
                else if (cfu_ram_ack) state_next = ST_MAC;
            end
            ST_MAC: begin
                state_next = last_pair ? ST_RESP : ST_RD_IN;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // rsp_data is only written on the way into RESP, which keeps the payload steady while rsp_valid is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_base   <= '0;
            filt_base <= '0;
            count     <= '0;
            idx       <= '0;
            acc       <= '0;
            in_word   <= '0;
            flt_word  <= '0;
            rsp_data  <= '0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rsp_data <= '0;
                        case (op)
                            FN_CONFIG: begin
                                filt_base <= cmd_payload_inputs_0[31:2];
                                count     <= cmd_payload_inputs_1[CNT_W-1:0];
                            end
                            FN_RUN: begin
                                in_base <= cmd_payload_inputs_0[31:2];
                                acc     <= '0;
                                idx     <= '0;
                            end
                            FN_STATUS: begin
                                rsp_data <= {31'b0, err_flag};
                                err_flag <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RD_IN: begin
                    if (cfu_ram_err) begin
                        err_flag <= 1'b1;
                        rsp_data <= ERR_RESULT;
                    end else if (cfu_ram_ack) begin
                        in_word <= cfu_ram_dat_miso;
                    end
                end
                ST_RD_FLT: begin
                    if (cfu_ram_err) begin
                        err_flag <= 1'b1;
                        rsp_data <= ERR_RESULT;
                    end else if (cfu_ram_ack) begin
                        flt_word <= cfu_ram_dat_miso;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    idx <= idx + CNT_W'(1);
                    if (last_pair) rsp_data <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Self-checking bench for cfu_mac_sequencer: table vectors, randomized runs against a dot-product model, and bus-error/reset/hold sequences.
module tb_cfu_mac_sequencer;

    localparam int INPUT_OFFSET = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_payload_outputs_0;
    logic [29:0] cfu_ram_adr;
    logic [31:0] cfu_ram_dat_mosi, cfu_ram_dat_miso;
    logic [3:0]  cfu_ram_sel;
    logic        cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, cfu_ram_ack, cfu_ram_err;
    logic [2:0]  cfu_ram_cti;
    logic [1:0]  cfu_ram_bte;

    always #5 clk = ~clk;

    cfu_mac_sequencer #(.INPUT_OFFSET(INPUT_OFFSET), .CNT_W(16)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .cfu_ram_adr             (cfu_ram_adr),
        .cfu_ram_dat_mosi        (cfu_ram_dat_mosi),
        .cfu_ram_sel             (cfu_ram_sel),
        .cfu_ram_cyc             (cfu_ram_cyc),
        .cfu_ram_stb             (cfu_ram_stb),
        .cfu_ram_we              (cfu_ram_we),
        .cfu_ram_cti             (cfu_ram_cti),
        .cfu_ram_bte             (cfu_ram_bte),
        .cfu_ram_dat_miso        (cfu_ram_dat_miso),
        .cfu_ram_ack             (cfu_ram_ack),
        .cfu_ram_err             (cfu_ram_err)
    );

    logic [31:0] mem [logic [29:0]];
    int   wait_states = 0;
    int   err_beat = -1;
    int   wait_cnt = 0;
    int   beat_cnt = 0;
    int   adr_violations = 0;
    int   cyc_cycles = 0;
    logic prev_pending = 1'b0;
    logic [29:0] prev_adr = '0;
    logic bus_done;
    int   tests = 0;
    int   failures = 0;

    function automatic logic [31:0] memRead(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // RAM slave: ack after wait_states idle cycles; err is raised together with ack on the armed beat
    always @(cfu_ram_adr or cfu_ram_stb) cfu_ram_dat_miso = cfu_ram_stb ? memRead(cfu_ram_adr) : 32'h0;

    always @* begin
        bus_done    = cfu_ram_stb && (wait_cnt >= wait_states);
        cfu_ram_ack = bus_done;
        cfu_ram_err = bus_done && (beat_cnt == err_beat);
    end

    always @(posedge clk) begin
        if (cfu_ram_cyc) cyc_cycles <= cyc_cycles + 1;
        if (cfu_ram_stb && prev_pending && cfu_ram_adr != prev_adr) adr_violations <= adr_violations + 1;
        prev_pending <= cfu_ram_stb && !bus_done;
        prev_adr     <= cfu_ram_adr;
        if (cfu_ram_stb && bus_done) begin
            wait_cnt <= 0;
            beat_cnt <= beat_cnt + 1;
        end else if (cfu_ram_stb) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Reference: plain integer dot product over the words the RUN should visit
    function automatic logic [31:0] modelDot(input logic [29:0] ib, input logic [29:0] fb, input int n);
        longint acc;
        longint s;
        logic [31:0] w, f;
        int a, b;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            w = memRead(ib + 30'(i));
            f = memRead(fb + 30'(i));
            s = 0;
            for (int k = 0; k < 4; k++) begin
                a = int'($signed(w[8*k +: 8])) + INPUT_OFFSET;
                b = int'($signed(f[8*k +: 8]));
                s = s + longint'(a * b);
            end
            acc = acc + s;
`ifdef CFU_MAC_SAT_EN
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
            acc = longint'($signed(acc[31:0]));
`endif
        end
        return acc[31:0];
    endfunction

    // Edges after the accepting edge until rsp_valid: quick ops show it on the accepting edge itself
    function automatic int runLat(input int n, input int w);
        return (n == 0) ? 0 : 3 * n + 2 * n * w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic applyStimulus(input logic [9:0] fn, input logic [31:0] in0, input logic [31:0] in1,
                                 input int hold, input logic [31:0] hold_exp,
                                 output logic [31:0] resp, output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) reportTimeout("cmd_ready");
        cmd_valid = 1'b1;
        cmd_payload_function_id = fn;
        cmd_payload_inputs_0 = in0;
        cmd_payload_inputs_1 = in1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 4000) begin
            @(posedge clk); #1;
            lat++;
        end
        resp = rsp_payload_outputs_0;
        if (!rsp_valid) begin
            reportTimeout("rsp_valid");
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
                checkOutput("hold_payload", rsp_payload_outputs_0, hold_exp);
                checkOutput("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic runCheck(input string name, input logic [9:0] fn, input logic [31:0] in0,
                            input logic [31:0] in1, input logic [31:0] exp_resp, input int exp_lat,
                            input int hold = 0);
        logic [31:0] resp;
        int lat;
        applyStimulus(fn, in0, in1, hold, exp_resp, resp, lat);
        checkOutput({name, "_resp"}, resp, exp_resp);
        checkOutput({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    typedef struct {
        logic [9:0]  fn;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] exp_resp;
        int          exp_lat;
    } vec_t;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[9];
        logic [29:0] ib, fb;
        int n;
        int c0;
        int guard;

        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;

        mem[30'h800] = 32'h0000_0000;
        mem[30'h400] = 32'h0101_0101;
        for (int i = 0; i < 4; i++) begin
            mem[30'h1400 + 30'(i)] = 32'h7F7F_7F7F;
            mem[30'h1000 + 30'(i)] = 32'h8080_8080;
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_payload", rsp_payload_outputs_0, 32'd0);
        checkOutput("reset_cyc_stb", {30'b0, cfu_ram_cyc, cfu_ram_stb}, 32'd0);
        checkOutput("reset_adr", {2'b0, cfu_ram_adr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{10'h000, 32'h0000_1000, 32'd1,         32'd512 * 0,      0};
        vecs[1] = '{10'h001, 32'h0000_2000, 32'd0,         32'd512,          3};
        vecs[2] = '{10'h000, 32'h0000_4000, 32'd4,         32'd0,            0};
        vecs[3] = '{10'h005, 32'hDEAD_0000, 32'd7,         32'd0,            0};
        vecs[4] = '{10'h001, 32'h0000_5000, 32'd0,         32'hFFF8_0800,    12};
        vecs[5] = '{10'h002, 32'h0000_0000, 32'd0,         32'd0,            0};
        vecs[6] = '{10'h3F8, 32'h0000_1000, 32'h1234_0001, 32'd0,            0};
        vecs[7] = '{10'h2C9, 32'h0000_2003, 32'd0,         32'd512,          3};
        vecs[8] = '{10'h007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,            0};
        for (int i = 0; i < 9; i++)
            runCheck($sformatf("vec%0d", i), vecs[i].fn, vecs[i].in0, vecs[i].in1,
                     vecs[i].exp_resp, vecs[i].exp_lat);

        for (int r = 0; r < 25; r++) begin
            wait_states = $urandom_range(0, 2);
            n  = $urandom_range(1, 6);
            ib = (r == 0) ? 30'h3FFF_FFFF : 30'($urandom);
            fb = 30'($urandom);
            for (int i = 0; i < n; i++) begin
                mem[ib + 30'(i)] = $urandom;
                mem[fb + 30'(i)] = $urandom;
            end
            runCheck($sformatf("rnd%0d_cfg", r), 10'd0, {fb, 2'b00}, 32'(n), 32'd0, 0);
            runCheck($sformatf("rnd%0d_run", r), 10'd1, {ib, 2'($urandom_range(0, 3))},
                     32'($urandom_range(0, 255)), modelDot(ib, fb, n), runLat(n, wait_states));
        end

        // Two wait states on every beat, two pairs
        wait_states = 2;
        mem[30'h1800] = 32'h0102_FF80; mem[30'h1801] = 32'h7F00_0180;
        mem[30'h1C00] = 32'h8001_7F02; mem[30'h1C01] = 32'hFF10_2030;
        runCheck("wait_cfg", 10'd0, 32'h0000_6000, 32'd2, 32'd0, 0);
        runCheck("wait_run", 10'd1, 32'h0000_7000, 32'd0, modelDot(30'h1C00, 30'h1800, 2), 14);

        // Bus error raised alongside ack on the second filter read
        wait_states = 0;
        err_beat = beat_cnt + 3;
        runCheck("err_run", 10'd1, 32'h0000_7000, 32'd0, 32'h8000_0000, 5);
        err_beat = -1;
        runCheck("status_set", 10'd2, 32'd0, 32'd0, 32'd1, 0);
        runCheck("status_clr", 10'd2, 32'd0, 32'd0, 32'd0, 0);

        // count=0: immediate zero response with no bus activity, then a held response
        runCheck("zero_cfg", 10'd0, 32'h0000_6000, 32'd0, 32'd0, 0);
        c0 = cyc_cycles;
        runCheck("zero_run", 10'd1, 32'h0000_7000, 32'd0, 32'd0, 0, 5);
        checkOutput("zero_no_cyc", 32'(cyc_cycles), 32'(c0));

        // Reset in the middle of a filter read
        wait_states = 3;
        runCheck("rst_cfg", 10'd0, 32'h0000_6000, 32'd2, 32'd0, 0);
        cmd_valid = 1'b1;
        cmd_payload_function_id = 10'd1;
        cmd_payload_inputs_0 = 32'h0000_7000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (!(cfu_ram_cyc && cfu_ram_adr == 30'h1800) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) reportTimeout("rst_find_rd_flt");
        checkOutput("bus_sel", {28'b0, cfu_ram_sel}, 32'hF);
        checkOutput("bus_we", {31'b0, cfu_ram_we}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst_cyc_stb", {30'b0, cfu_ram_cyc, cfu_ram_stb}, 32'd0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_states = 0;
        @(posedge clk); #1;
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        runCheck("rst_run", 10'd1, 32'h0000_7000, 32'd0, 32'd0, 0);

        checkOutput("adr_stable", 32'(adr_violations), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
